// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, addresses the ROM and
// registers the returned word into an instruction register that is offered
// to decode through a valid/ready handshake. Supports start, backpressure,
// branch redirect with flush, and a halt opcode that freezes fetch.
module fetch_unit #(
  parameter int          ADDR_W  = 4,
  parameter int          DATA_W  = 32,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] addr_ROM,
  input  logic [DATA_W-1:0] d_ROM,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc_instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_reg,    state_next;
  logic [ADDR_W-1:0] pc_reg,       pc_next;
  logic [DATA_W-1:0] instr_reg,    instr_next;
  logic [ADDR_W-1:0] pc_instr_reg, pc_instr_next;
  logic              valid_reg,    valid_next;

  logic              is_halt_word;
  logic              slot_free;

  // The opcode field always occupies the top six bits of the word.
  assign is_halt_word = (d_ROM[DATA_W-1 -: 6] == HALT_OP);
  // The instruction register can accept a new word when empty or being drained.
  assign slot_free    = !valid_reg || instr_ready;

  // Next-state logic: branch redirect outranks every per-state action.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    pc_instr_next = pc_instr_reg;
    valid_next    = valid_reg;

    if (branch_en && (state_reg != IDLE)) begin
      // Flush: the held word is discarded; instr/pc_instr keep stale contents.
      pc_next    = branch_addr;
      valid_next = 1'b0;
      state_next = RUN;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (slot_free) begin
            instr_next    = d_ROM;
            pc_instr_next = pc_reg;
            valid_next    = 1'b1;
            if (is_halt_word) begin
              // PC parks on the halt word so addr_ROM stays there.
              state_next = HALT;
            end else begin
              pc_next = pc_reg + ADDR_W'(1);
            end
          end
        end
        HALT: begin
          if (valid_reg && instr_ready) begin
            valid_next = 1'b0;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= '0;
      instr_reg    <= '0;
      pc_instr_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      pc_instr_reg <= pc_instr_next;
      valid_reg    <= valid_next;
    end
  end

  assign addr_ROM    = pc_reg;
  assign instr       = instr_reg;
  assign pc_instr    = pc_instr_reg;
  assign instr_valid = valid_reg;
  assign halted      = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// all compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  addr_ROM;
  logic [31:0] d_ROM;
  logic        branch_en;
  logic [3:0]  branch_addr;
  logic [31:0] instr;
  logic [3:0]  pc_instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;

  logic [31:0] rom [16];

  int total = 0;
  int bad   = 0;

  // Reference model (mode: 0 idle, 1 running, 2 halted)
  int          m_mode;
  logic [3:0]  m_pc;
  logic [31:0] m_instr;
  logic [3:0]  m_pci;
  logic        m_valid;
  int          xfers = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .addr_ROM    (addr_ROM),
    .d_ROM       (d_ROM),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .instr       (instr),
    .pc_instr    (pc_instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  assign d_ROM = rom[addr_ROM];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, update the model from the applied inputs, and
  // compare every DUT output against it.
  task automatic cycle();
    int          n_mode;
    logic [3:0]  n_pc;
    logic [31:0] n_instr;
    logic [3:0]  n_pci;
    logic        n_valid;
    logic [31:0] w;
    bit          xfer;
    n_mode = m_mode; n_pc = m_pc; n_instr = m_instr; n_pci = m_pci; n_valid = m_valid;
    xfer = 1'b0;
    if (!rst_n) begin
      n_mode = 0; n_pc = 0; n_instr = 0; n_pci = 0; n_valid = 0;
    end else if (branch_en && m_mode != 0) begin
      n_mode = 1; n_pc = branch_addr; n_valid = 0;
    end else if (m_mode == 0) begin
      if (start) n_mode = 1;
    end else if (m_mode == 1) begin
      xfer = m_valid && instr_ready;
      if (!m_valid || instr_ready) begin
        w = rom[m_pc];
        n_instr = w; n_pci = m_pc; n_valid = 1;
        if (w[31:26] == 6'h3F) n_mode = 2;
        else n_pc = 4'((int'(m_pc) + 1) % 16);
      end
    end else begin
      xfer = m_valid && instr_ready;
      if (xfer) n_valid = 0;
    end
    if (xfer) begin
      xfers++;
      $display("xfer %0d: pc=%0d instr=%h", xfers, m_pci, m_instr);
    end
    @(posedge clk);
    #1;
    m_mode = n_mode; m_pc = n_pc; m_instr = n_instr; m_pci = n_pci; m_valid = n_valid;
    chk("addr_ROM", 32'(addr_ROM), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("instr", instr, m_instr);
    chk("pc_instr", 32'(pc_instr), 32'(m_pci));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'h0000_1000 + 32'(i);
    rom[0]  = 32'h0041_0002;
    rom[1]  = 32'h0022_0006;
    rom[2]  = 32'h0822_0002;
    rom[3]  = 32'h0000_0005;
    rom[4]  = 32'h0000_0004;
    rom[5]  = 32'hFC00_0000;
    rom[14] = 32'h0000_0000;
    rom[15] = 32'h0000_0001;

    m_mode = 0; m_pc = 0; m_instr = 0; m_pci = 0; m_valid = 0;
    rst_n = 0; start = 0; branch_en = 0; branch_addr = 0; instr_ready = 1;

    // Reset
    cycle(); cycle();
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_addr", 32'(addr_ROM), 0);
    chk("rst_halted", 32'(halted), 0);

    // Start: first word valid two edges after start
    rst_n = 1; cycle();
    start = 1; cycle();
    chk("start_no_fetch", 32'(instr_valid), 0);
    start = 0; cycle();
    chk("first_instr", instr, 32'h0041_0002);
    chk("first_pc", 32'(pc_instr), 0);
    cycle();
    chk("second_instr", instr, 32'h0022_0006);

    // Backpressure on ROM[1]
    instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_instr", instr, 32'h0022_0006);
      chk("stall_pc", 32'(pc_instr), 1);
      chk("stall_addr", 32'(addr_ROM), 2);
    end
    instr_ready = 1; cycle();
    chk("after_stall_instr", instr, 32'h0822_0002);
    chk("after_stall_pc", 32'(pc_instr), 2);
    cycle();
    chk("rom3_instr", instr, 32'h0000_0005);

    // Branch/flush to 14, then wrap
    branch_en = 1; branch_addr = 14; cycle();
    chk("bubble", 32'(instr_valid), 0);
    branch_en = 0; cycle();
    chk("tgt14_instr", instr, 32'h0000_0000);
    chk("tgt14_pc", 32'(pc_instr), 14);
    cycle();
    chk("tgt15_instr", instr, 32'h0000_0001);
    chk("tgt15_pc", 32'(pc_instr), 15);
    cycle();
    chk("wrap_instr", instr, 32'h0041_0002);
    chk("wrap_pc", 32'(pc_instr), 0);

    // Run to the halt word at address 5
    for (int i = 0; i < 5; i++) cycle();
    chk("halt_instr", instr, 32'hFC00_0000);
    chk("halt_pc", 32'(pc_instr), 5);
    chk("halt_flag", 32'(halted), 1);
    cycle();
    chk("halt_drained", 32'(instr_valid), 0);
    chk("halt_addr", 32'(addr_ROM), 5);
    start = 1; cycle();
    chk("halt_start_ign", 32'(halted), 1);
    chk("halt_addr2", 32'(addr_ROM), 5);
    start = 0; branch_en = 1; branch_addr = 0; cycle();
    chk("halt_br_bubble", 32'(instr_valid), 0);
    branch_en = 0; cycle();
    chk("restart_instr", instr, 32'h0041_0002);

    // Reset during a stall
    instr_ready = 0; cycle();
    rst_n = 0; cycle();
    chk("midrst_valid", 32'(instr_valid), 0);
    chk("midrst_instr", instr, 0);
    chk("midrst_addr", 32'(addr_ROM), 0);
    rst_n = 1; instr_ready = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk("idle_no_fetch", 32'(instr_valid), 0);

    // Branch ignored in IDLE
    branch_en = 1; branch_addr = 9; cycle(); cycle();
    chk("idle_br_addr", 32'(addr_ROM), 0);
    branch_en = 0; start = 1; cycle();
    start = 0; cycle();
    chk("idle_br_fetch", instr, 32'h0041_0002);
    chk("idle_br_pc", 32'(pc_instr), 0);

    // Randomized traffic with a reshuffled ROM image (occasional halts)
    for (int i = 6; i < 14; i++) begin
      rom[i] = $urandom();
      if ($urandom_range(0, 7) == 0) rom[i][31:26] = 6'h3F;
      else if (rom[i][31:26] == 6'h3F) rom[i][31] = 1'b0;
    end
    for (int i = 0; i < 400; i++) begin
      rst_n       = ($urandom_range(0, 99) >= 2);
      start       = ($urandom_range(0, 9) == 0);
      branch_en   = ($urandom_range(0, 99) < 8);
      branch_addr = 4'($urandom_range(0, 15));
      instr_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction ROM and feeds the decode stage. Holds the program counter, drives the ROM address, and registers the returned 32-bit word into an instruction register. Presents the word to decode through a valid/ready handshake. Supports start, stall/backpressure, branch redirect with flush, and a halt instruction.

## Interface
- ADDR_W, 4: program counter / ROM address width; ROM depth = 2^ADDR_W.
- DATA_W, 32: instruction width.
- HALT_OP, 6'b111111: opcode value in instr[DATA_W-1:DATA_W-6] that halts fetch.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; leaves IDLE.
- addr_ROM  out  ADDR_W  ROM address; always equal to the PC register.
- d_ROM  in  DATA_W  ROM data; combinational function of addr_ROM, valid in the same cycle.
- branch_en  in  1  redirect request from execute.
- branch_addr  in  ADDR_W  redirect target.
- instr  out  DATA_W  registered instruction to decode.
- pc_instr  out  ADDR_W  address from which instr was fetched.
- instr_valid  out  1  instr/pc_instr hold a live instruction.
- instr_ready  in  1  decode accepts instr this cycle.
- halted  out  1  high while in HALT.

## Operation
- States: IDLE, RUN, HALT. Reset values: IDLE, pc=0, instr=0, pc_instr=0, instr_valid=0, halted=0.
- Transfer: decode consumes the instruction on an edge where instr_valid=1 and instr_ready=1.
- load = (state==RUN) && !branch_en && (!instr_valid || instr_ready).
- On load: instr<=d_ROM, pc_instr<=pc, instr_valid<=1.
  - If d_ROM[31:26]!=HALT_OP: pc<=pc+1, modulo 2^ADDR_W, so 15 wraps to 0.
  - If d_ROM[31:26]==HALT_OP: pc unchanged, state<=HALT. The halt word itself is still presented to decode.
- RUN with instr_valid=1 and instr_ready=0 (stall): instr, pc_instr, instr_valid and pc all hold.
- RUN with instr_valid=1, instr_ready=1 and no branch: the consumed word is replaced by the new load in the same edge, giving back-to-back issue.
- IDLE:
  - start=1 -> RUN. No fetch on that edge.
  - branch_en is ignored in IDLE.
- HALT:
  - No loads.
  - instr_valid drops on the edge its word is consumed.
  - halted=1.
  - start is ignored.
- branch_en=1 in RUN or HALT, which has priority over everything except reset:
  - pc<=branch_addr, instr_valid<=0, state<=RUN.
  - The held instruction is discarded even if instr_ready=1 in the same cycle; no transfer counts.
  - instr and pc_instr keep stale values; they are don't-care while invalid.
- rst_n=0 on any edge, including mid-stall, mid-branch or in HALT: all state returns to reset values and overrides every other input.

## Timing
- start at edge E0 -> RUN after E0. First load at E1, so instr_valid=1 with ROM[0] after E1: 2 cycles from start.
- Fetch throughput: 1 instruction/cycle while instr_ready=1.
- Branch at edge B: no valid instruction after B (one bubble). Target word is valid after B+1.
- addr_ROM changes only on clock edges and is glitch-free relative to the PC register.
- halted asserts the cycle after the halt word is loaded, coincident with that word being valid.

## Test plan
- Reset/start: hold rst_n=0 for 2 cycles, then pulse start, instr_ready=1, current ROM image. Required response:
  - Outputs are 0 during reset.
  - After start, consecutive valid cycles show 0x00410002, 0x00220006, 0x08220002, 0x00000005 with pc_instr 0,1,2,3.
- Backpressure: instr_ready=0 for 3 cycles while ROM[1] is valid. instr stays 0x00220006, pc_instr=1, and addr_ROM=2 throughout. On ready=1, ROM[2] follows on the next cycle with no word lost or duplicated.
- Branch/flush: branch_en=1, branch_addr=14 with ready=1 while ROM[3] is valid. Required response:
  - instr_valid=0 for one cycle.
  - Then 0x00000000 with pc_instr=14, then 0x00000001 with pc_instr=15.
  - Then ROM[0]=0x00410002 with pc_instr=0 (wrap).
- Halt: behavioural ROM returns 0xFC000000 at address 5. Required response:
  - The word is presented with pc_instr=5 and halted=1.
  - After it is consumed instr_valid=0; addr_ROM stays 5 and start is ignored.
  - A branch to 0 restarts fetch with ROM[0] two cycles later.
- Reset mid-operation: assert rst_n=0 during a stall with instr_valid=1. On the next edge all outputs are 0 and state is IDLE. No fetch occurs until a new start.
- Branch ignored in IDLE: after reset, branch_en=1, branch_addr=9 without start. addr_ROM stays 0; a later start fetches ROM[0].
